uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits checked, 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 = even, 1 = odd; used only when UART_RX_PARITY_EN is defined.
REQ-005 SHALL have port clk  input  1: single clock; all logic on posedge clk.
REQ-006 SHALL have port rst  input  1: asynchronous active-low reset.
REQ-007 SHALL have port rx  input  1: asynchronous serial line, idle high, LSB first.
REQ-008 SHALL have port data  output  DATA_BITS: last received word.
REQ-009 SHALL have port valid  output  1: data holds an unconsumed word.
REQ-010 SHALL have port ready  input  1: consumer accepts data when valid && ready.
REQ-011 SHALL have port frame_err  output  1: stop-bit error flag for the word in data.
REQ-012 SHALL have port parity_err  output  1: parity error flag for the word in data.
REQ-013 SHALL have port overrun  output  1: sticky flag, a frame was dropped.
REQ-014 SHALL have port state  output  3: current FSM state encoding, for debug.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer, reset to 1; all FSM decisions use the synchronized value rxs.
REQ-016 SHALL implement FSM states IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; encodings 5-7 SHALL go to IDLE.
REQ-017 IDLE: on rxs==0, SHALL go to START and load the bit counter.
REQ-018 START: after CLKS_PER_BIT/2 cycles, SHALL re-sample rxs; if 1 (glitch), SHALL go to IDLE with no output change; if 0, SHALL go to DATA.
REQ-019 DATA: SHALL sample rxs every CLKS_PER_BIT cycles into a shift register, LSB first, DATA_BITS samples; after the last sample, SHALL go to PARITY (parity enabled) or STOP.
REQ-020 PARITY: SHALL sample one bit CLKS_PER_BIT after the last data sample; error = XOR(data bits, parity bit) != PARITY_ODD.
REQ-021 STOP: SHALL sample each stop bit at its midpoint; any 0 sets frame error; after the last stop sample, SHALL go directly to IDLE without waiting for the bit end.
REQ-022 On the last stop sample cycle, if valid==0 or ready==1, SHALL load data, frame_err and parity_err, and assert valid on the next cycle.
REQ-023 If valid==1 and ready==0 on that cycle, SHALL discard the new frame, keep data/flags, and set overrun.
REQ-024 valid SHALL clear on the cycle after valid && ready unless a new word is loaded on the same cycle, in which case valid stays 1.
REQ-025 overrun SHALL stay 1 until the next valid && ready handshake, then clear.
REQ-026 The bit-period counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide and SHALL not wrap within a bit.
REQ-027 rx activity during STOP handling SHALL NOT be lost: a falling rxs in the IDLE cycle after STOP SHALL start a new frame.

Reset
REQ-028 rst low SHALL asynchronously force state=IDLE, data=0, valid=0, frame_err=0, parity_err=0, overrun=0, counters=0, synchronizer=1.
REQ-029 Reset mid-frame SHALL abandon the frame; the first full frame after release SHALL be received correctly.

Configuration
REQ-030 With UART_RX_PARITY_EN defined, the PARITY state and parity check SHALL be present.
REQ-031 Without UART_RX_PARITY_EN, the FSM SHALL skip PARITY (DATA to STOP), and parity_err SHALL be tied to 0.

Verification
REQ-032 CLKS_PER_BIT=16, DATA_BITS=8: send 0xA5 with 1 stop bit -> valid=1, data=0xA5, frame_err=0, parity_err=0.
REQ-033 Pulse rx low for 4 cycles -> state returns to IDLE and valid stays 0.
REQ-034 Send 0x3C with stop bit = 0 -> data=0x3C, frame_err=1.
REQ-035 Hold ready=0 and send 0x11 then 0x22 back to back -> data=0x11, overrun=1; after a handshake -> overrun=0.
REQ-036 UART_RX_PARITY_EN, PARITY_ODD=1: send 0x01 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.
REQ-037 Assert rst during DATA of 0x55, then send 0x9E -> all outputs 0 during reset, then data=0x9E and valid=1.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parameterized UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-word output buffer with overrun flag.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic [2:0]           state
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] FULL   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    LAST_D = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_S = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               st;
    logic                 rx_meta, rxs;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc;
    logic                 hs;
`ifdef UART_RX_PARITY_EN
    logic                 perr_acc;
`else
    assign parity_err = 1'b0;
`endif

    assign hs    = valid && ready;
    assign state = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            ferr_acc  <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc   <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            // Handshake clears first; a word loaded this same cycle overrides valid below.
            if (hs) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
            case (st)
                IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_acc <= 1'b0;
`endif
                    if (!rxs) st <= START;
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        st  <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_D) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            st <= PARITY;
`else
                            st <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL) begin
                        cnt      <= '0;
                        perr_acc <= ((^shreg) ^ rxs) != PARITY_ODD[0];
                        st       <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (!rxs) ferr_acc <= 1'b1;
                        // Leave at the last stop midpoint so a following start edge is not missed.
                        if (bit_idx == LAST_S) begin
                            bit_idx <= '0;
                            st      <= IDLE;
                            if (!valid || ready) begin
                                data       <= shreg;
                                frame_err  <= ferr_acc | ~rxs;
`ifdef UART_RX_PARITY_EN
                                parity_err <= perr_acc;
`endif
                                valid      <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: directed frames push expected words, a monitor pops on each handshake.
module tb_uart_rx_param;
    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int SB   = 1;
    localparam int PODD = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic          ready = 1'b1;
    logic [DB-1:0] data;
    logic          valid, frame_err, parity_err, overrun;
    logic [2:0]    state;

    typedef struct {
        logic [DB-1:0] d;
        logic          fe;
        logic          pe;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails  = 0;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; par is only placed on the line in the parity build.
    task automatic send(input logic [DB-1:0] d, input logic stop_v, input logic par);
        rx = 1'b0; tick(CPB);
        for (int i = 0; i < DB; i++) begin rx = d[i]; tick(CPB); end
`ifdef UART_RX_PARITY_EN
        rx = par; tick(CPB);
`else
        if (par) rx = 1'b1;
`endif
        for (int s = 0; s < SB; s++) begin rx = stop_v; tick(CPB); end
        rx = 1'b1;
    endtask

    function automatic logic good_par(input logic [DB-1:0] d);
        return (^d) ^ PODD[0];
    endfunction

    task automatic push(input logic [DB-1:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe;
        sbq.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && sbq.size() != 0; i++) tick(1);
        chk("sb_drain", sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst && valid && ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_word", {24'h0, data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("data", {24'h0, data}, {24'h0, e.d});
                chk("frame_err", frame_err, e.fe);
                chk("parity_err", parity_err, e.pe);
            end
        end
    end

    initial begin
        tick(3);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_state", state, 0);
        rst = 1'b1;
        tick(2 * CPB);

        push(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 1'b1, good_par(8'hA5));
        tick(2 * CPB);
        drain();

        rx = 1'b0; tick(4); rx = 1'b1;
        tick(3 * CPB);
        chk("glitch_state", state, 0);
        chk("glitch_valid", valid, 0);

        push(8'h3C, 1'b1, 1'b0);
        send(8'h3C, 1'b0, good_par(8'h3C));
        tick(3 * CPB);
        drain();

`ifdef UART_RX_PARITY_EN
        push(8'h01, 1'b0, 1'b1);
        send(8'h01, 1'b1, 1'b1);
        tick(2 * CPB);
        drain();
        push(8'h01, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b0);
        tick(2 * CPB);
        drain();
`endif

        ready = 1'b0;
        push(8'h11, 1'b0, 1'b0);
        send(8'h11, 1'b1, good_par(8'h11));
        send(8'h22, 1'b1, good_par(8'h22));
        tick(2 * CPB);
        chk("ovr_data", data, 8'h11);
        chk("ovr_valid", valid, 1);
        chk("ovr_flag", overrun, 1);
        ready = 1'b1;
        tick(2);
        chk("ovr_cleared", overrun, 0);
        chk("ovr_valid_clr", valid, 0);
        drain();

        rx = 1'b0; tick(CPB);
        rx = 1'b1; tick(CPB);
        rx = 1'b0; tick(CPB);
        rx = 1'b1; tick(CPB / 2);
        rst = 1'b0;
        tick(1);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_perr", parity_err, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_state", state, 0);
        tick(3);
        rst = 1'b1;
        tick(2 * CPB);
        push(8'h9E, 1'b0, 1'b0);
        send(8'h9E, 1'b1, good_par(8'h9E));
        tick(2 * CPB);
        drain();
        chk("final_state", state, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
